per_fifo_bridge: RTL

PER_FIFO_BRIDGE -- requirements
Module: per_fifo_bridge

---
 rtl/per_fifo_pkg.sv | 60 ++++++
 rtl/per_fifo_core.sv | 71 +++++++
 rtl/per_fifo_bridge.sv | 116 +++++++++++
 3 files changed

// File: rtl/per_fifo_pkg.sv
// Shared definitions for the peripheral FIFO bridge: register offsets, STATUS/CTRL
// bit positions and the access-decode helpers used by per_fifo_bridge.
package per_fifo_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 14;
  localparam int REG_SPAN = 4;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_RESULT = 2'd2,
    REG_CTRL   = 2'd3
  } reg_off_e;

  typedef enum logic [1:0] {
    ACC_NONE  = 2'd0,
    ACC_READ  = 2'd1,
    ACC_WRITE = 2'd2
  } acc_kind_e;

  typedef struct packed {
    logic      hit;
    acc_kind_e kind;
    reg_off_e  off;
  } per_dec_t;

  localparam int STAT_CNT_LSB      = 0;
  localparam int STAT_CNT_W        = 7;
  localparam int STAT_OVF_BIT      = 7;
  localparam int STAT_RES_FULL_BIT = 8;

  localparam int CTRL_FLUSH_BIT    = 0;
  localparam int CTRL_OVF_CLR_BIT  = 1;

  // Only full-word accesses count; partial byte enables are treated as no access.
  function automatic acc_kind_e acc_kind(input logic [1:0] we);
    acc_kind_e k;
    case (we)
      2'b11:   k = ACC_WRITE;
      2'b00:   k = ACC_READ;
      default: k = ACC_NONE;
    endcase
    return k;
  endfunction

  function automatic logic [DATA_W-1:0] status_word(
    input logic                  res_full,
    input logic                  ovf,
    input logic [STAT_CNT_W-1:0] count
  );
    logic [DATA_W-1:0] w;
    w = '0;
    w[STAT_RES_FULL_BIT]               = res_full;
    w[STAT_OVF_BIT]                    = ovf;
    w[STAT_CNT_LSB +: STAT_CNT_W]      = count;
    return w;
  endfunction

endpackage

// File: rtl/per_fifo_core.sv
// Circular FIFO: storage, read/write pointers and occupancy count. No fall-through;
// head is the stored word at the read pointer, forced to zero when empty.
module per_fifo_core #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic             mclk,
  input  logic             puc_rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             empty,
  output logic [6:0]       count,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [AW:0]      count_reg, count_next;
  logic             push_ok, pop_ok;
  logic [WIDTH-1:0] entry [DEPTH];

  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign empty = (count_reg == '0);

  // Full is judged on the pre-pop occupancy, so a push into a full FIFO is lost
  // even when a pop frees a slot in the same cycle.
  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~empty & ~flush;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push_ok) wr_ptr_next = wr_ptr_reg + AW'(1);
    if (pop_ok)  rd_ptr_next = rd_ptr_reg + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + (AW+1)'(1);
      2'b01:   count_next = count_reg - (AW+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (!puc_rst_n || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [WIDTH-1:0] entry_reg;
    always_ff @(posedge mclk) begin
      if (push_ok && (wr_ptr_reg == AW'(gi))) entry_reg <= push_data;
    end
    assign entry[gi] = entry_reg;
  end

  assign head  = empty ? '0 : entry[rd_ptr_reg];
  assign count = 7'(count_reg);

endmodule

// File: rtl/per_fifo_bridge.sv
// Peripheral-bus bridge: DATA/STATUS/RESULT/CTRL registers in front of an input FIFO
// and a one-word result holding register. Define PER_FIFO_OVF_EN for the sticky overflow flag.
module per_fifo_bridge
  import per_fifo_pkg::*;
#(
  parameter logic [13:0] BASE_ADDR = 14'hA8,
  parameter int          DEPTH     = 8
) (
  input  logic        mclk,
  input  logic        puc_rst_n,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  output logic [15:0] s_data,
  output logic        s_valid,
  input  logic        s_ready,
  input  logic [15:0] r_data,
  input  logic        r_valid,
  output logic        r_ready
);

  logic [13:0] addr_off;
  per_dec_t    dec;
  logic        wr_data, wr_ctrl, rd_status, rd_result;
  logic        push, pop, flush;
  logic        full, empty;
  logic [6:0]  count;
  logic [15:0] head;
  logic        ovf;
  logic        capture, res_clr;
  logic        res_full_reg;
  logic [15:0] res_data_reg;

  // Unsigned difference wraps for addresses below BASE_ADDR, so one compare covers both sides.
  always_comb begin
    addr_off = per_addr - BASE_ADDR;
    dec.hit  = per_en && (addr_off < 14'(REG_SPAN));
    dec.kind = dec.hit ? acc_kind(per_we) : ACC_NONE;
    dec.off  = reg_off_e'(addr_off[1:0]);
  end

  assign wr_data   = (dec.kind == ACC_WRITE) && (dec.off == REG_DATA);
  assign wr_ctrl   = (dec.kind == ACC_WRITE) && (dec.off == REG_CTRL);
  assign rd_status = (dec.kind == ACC_READ)  && (dec.off == REG_STATUS);
  assign rd_result = (dec.kind == ACC_READ)  && (dec.off == REG_RESULT);

  assign flush = wr_ctrl & per_din[CTRL_FLUSH_BIT];
  assign push  = wr_data & ~full;
  assign pop   = s_valid & s_ready;

  per_fifo_core #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W)
  ) u_core (
    .mclk      (mclk),
    .puc_rst_n (puc_rst_n),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .push_data (per_din),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .head      (head)
  );

  assign s_valid = ~empty;
  assign s_data  = head;
  assign r_ready = ~res_full_reg;

  assign capture = r_valid & ~res_full_reg;
  assign res_clr = rd_result & res_full_reg;

  // Flush outranks capture; capture and read-clear are exclusive on res_full.
  always_ff @(posedge mclk) begin
    if (!puc_rst_n) begin
      res_full_reg <= 1'b0;
      res_data_reg <= '0;
    end else if (flush) begin
      res_full_reg <= 1'b0;
    end else if (capture) begin
      res_full_reg <= 1'b1;
      res_data_reg <= r_data;
    end else if (res_clr) begin
      res_full_reg <= 1'b0;
    end
  end

`ifdef PER_FIFO_OVF_EN
  logic ovf_reg;
  always_ff @(posedge mclk) begin
    if (!puc_rst_n) begin
      ovf_reg <= 1'b0;
    end else if (wr_data && full) begin
      ovf_reg <= 1'b1;
    end else if (wr_ctrl && per_din[CTRL_OVF_CLR_BIT]) begin
      ovf_reg <= 1'b0;
    end
  end
  assign ovf = ovf_reg;
`else
  assign ovf = 1'b0;
`endif

  always_comb begin
    per_dout = '0;
    if (rd_status) begin
      per_dout = status_word(res_full_reg, ovf, count);
    end else if (rd_result && res_full_reg) begin
      per_dout = res_data_reg;
    end
  end

endmodule
